radix8_mult_seq: RTL



---
 rtl/radix8_mult_seq.sv | 86 ++++++++
 1 files changed

// File: rtl/radix8_mult_seq.sv
// rtl/radix8_mult_seq.sv - sequential unsigned 16x15 radix-8 multiplier controller
// Retires one 3-bit multiplier digit per clock; the external mux bank returns ALatch*Sel on PPIn.
module radix8_mult_seq (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] MultA,
    input  logic [14:0] MultB,
    output logic [15:0] ALatch,
    output logic [2:0]  Sel,
    input  logic [18:0] PPIn,
    output logic        Busy,
    output logic        Done,
    output logic [30:0] Product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateType;

    stateType    state;
    logic [2:0]  cnt;
    logic [14:0] bReg;
    logic [30:0] acc;

    logic [4:0]  shiftAmt;
    logic [30:0] addend;
    logic [30:0] accNext;

    // Digit weight is 8^cnt, i.e. a left shift of 3*cnt bits.
    always_comb begin
        shiftAmt = {2'b00, cnt} + {1'b0, cnt, 1'b0};
        addend   = {12'b0, PPIn} << shiftAmt;
        accNext  = acc + addend;
        Sel      = (state == RUN) ? bReg[2:0] : 3'd0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            bReg    <= 15'd0;
            acc     <= 31'd0;
            ALatch  <= 16'd0;
            Product <= 31'd0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        ALatch <= MultA;
                        bReg   <= MultB;
                        acc    <= 31'd0;
                        cnt    <= 3'd0;
                        Busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc  <= accNext;
                    bReg <= bReg >> 3;
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd4) begin
                        Product <= accNext;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
